// File: rtl/alu_seq_pkg.sv
// Shared encodings for the ALU sequencer: op codes, FSM phases, flag bit
// positions and the packed datapath control vector.
`timescale 1ns/1ps
package alu_seq_pkg;

    typedef enum logic [2:0] {
        OP_ADD   = 3'd0,
        OP_SUB   = 3'd1,
        OP_AND   = 3'd2,
        OP_OR    = 3'd3,
        OP_EOR   = 3'd4,
        OP_SHR   = 3'd5,
        OP_PASSB = 3'd6,
        OP_RSVD  = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_EXEC = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // rsp_flags layout is {N,V,Z,C}
    localparam int FLAG_N = 3;
    localparam int FLAG_V = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_C = 0;
    localparam int FLAG_W = 4;

    typedef struct packed {
        logic a_sys;
        logic a_zero;
        logic b_data;
        logic b_inv;
        logic b_addr;
        logic alu_sum;
        logic alu_and;
        logic alu_or;
        logic alu_eor;
        logic alu_shr;
        logic carry_in;
    } ctrl_t;

    localparam int CTRL_W = $bits(ctrl_t);

    // Ops whose B operand source follows req_b_src; SUB and SHR do not.
    function automatic logic takes_b_src(input op_e op);
        return (op == OP_ADD) || (op == OP_AND) || (op == OP_OR) ||
               (op == OP_EOR) || (op == OP_PASSB);
    endfunction

endpackage

// File: rtl/alu_op_decoder.sv
// Pure combinational map from (op, b_src, carry, phase) to datapath controls.
// Only LOAD and EXEC phases produce non-zero controls.
`timescale 1ns/1ps
module alu_op_decoder
    import alu_seq_pkg::*;
(
    input  logic [2:0]        i_op,
    input  logic              i_b_src,
    input  logic              i_carry,
    input  logic [1:0]        i_phase,
    output logic [CTRL_W-1:0] o_ctrl
);

    ctrl_t w_ctrl;
    op_e   w_op;

    always_comb begin
        w_ctrl = '0;
        w_op   = op_e'(i_op);
        case (state_e'(i_phase))
            ST_LOAD: begin
                w_ctrl.a_sys  = (w_op != OP_PASSB) && (w_op != OP_RSVD);
                w_ctrl.a_zero = (w_op == OP_PASSB);
                if (w_op == OP_SUB) begin
                    w_ctrl.b_inv = 1'b1;
                end else if (takes_b_src(w_op)) begin
                    w_ctrl.b_addr = i_b_src;
                    w_ctrl.b_data = !i_b_src;
                end
            end
            ST_EXEC: begin
                case (w_op)
                    OP_ADD, OP_SUB: begin
                        w_ctrl.alu_sum  = 1'b1;
                        w_ctrl.carry_in = i_carry;
                    end
                    OP_PASSB: w_ctrl.alu_sum = 1'b1;
                    OP_AND:   w_ctrl.alu_and = 1'b1;
                    OP_OR:    w_ctrl.alu_or  = 1'b1;
                    OP_EOR:   w_ctrl.alu_eor = 1'b1;
                    OP_SHR:   w_ctrl.alu_shr = 1'b1;
                    default:  ;
                endcase
            end
            default: ;
        endcase
    end

    assign o_ctrl = w_ctrl;

endmodule

// File: rtl/alu_sequencer.sv
// Sequences one ALU operation through IDLE->LOAD->EXEC->DONE with registered
// controls; response holds in DONE until rsp_ready, requests ignored while busy.
`timescale 1ns/1ps
module alu_sequencer
    import alu_seq_pkg::*;
(
    input  logic       phi2,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [2:0] req_op,
    input  logic       req_b_src,
    input  logic       req_carry,
    output logic       a_systemBus_EN,
    output logic       a_zero_EN,
    output logic       b_dataBus_EN,
    output logic       b_dataBusInvert_EN,
    output logic       b_addressLow_EN,
    output logic       alu_sum_EN,
    output logic       alu_and_EN,
    output logic       alu_or_EN,
    output logic       alu_eor_EN,
    output logic       alu_shiftRight_EN,
    output logic       carry_FLAG_IN,
    input  logic [7:0] hold_REG_IN,
    input  logic       overflow_FLAG_IN,
    input  logic       carryOut_FLAG_IN,   // ALU carry-out (carry_FLAG_IN is the carry-in output)
    input  logic       negative_FLAG_IN,
    input  logic       zero_FLAG_IN,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_data,
    output logic [3:0] rsp_flags,
    output logic       rsp_err
);

    state_e              r_state;
    state_e              w_state_n;
    op_e                 r_op;
    logic                r_b_src;
    logic                r_carry;
    ctrl_t               r_ctrl;
    logic                r_req_ready;
    logic                r_rsp_valid;
    logic [7:0]          r_rsp_data;
    logic [FLAG_W-1:0]   r_rsp_flags;
    logic                r_rsp_err;

    logic                w_accept;
    op_e                 w_op_n;
    logic                w_b_src_n;
    logic                w_carry_n;
    logic [CTRL_W-1:0]   w_ctrl_n;

    assign w_accept  = (r_state == ST_IDLE) && r_req_ready && req_valid;
    assign w_op_n    = w_accept ? op_e'(req_op) : r_op;
    assign w_b_src_n = w_accept ? req_b_src : r_b_src;
    assign w_carry_n = w_accept ? req_carry : r_carry;

    always_ff @(posedge phi2) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_n;
    end

    always_comb begin
        w_state_n = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_state_n = (w_op_n == OP_RSVD) ? ST_DONE : ST_LOAD;
            ST_LOAD: w_state_n = ST_EXEC;
            ST_EXEC: w_state_n = ST_DONE;
            ST_DONE: if (rsp_ready) w_state_n = ST_IDLE;
            default: w_state_n = ST_IDLE;
        endcase
    end

    // Decoding the upcoming phase lets the control flops change in step with the state.
    alu_op_decoder u_dec (
        .i_op    (w_op_n),
        .i_b_src (w_b_src_n),
        .i_carry (w_carry_n),
        .i_phase (w_state_n),
        .o_ctrl  (w_ctrl_n)
    );

    always_ff @(posedge phi2) begin
        if (reset) begin
            r_op        <= OP_ADD;
            r_b_src     <= 1'b0;
            r_carry     <= 1'b0;
            r_ctrl      <= '0;
            r_req_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_flags <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_op        <= w_op_n;
            r_b_src     <= w_b_src_n;
            r_carry     <= w_carry_n;
            r_ctrl      <= ctrl_t'(w_ctrl_n);
            r_req_ready <= (w_state_n == ST_IDLE);
            r_rsp_valid <= (w_state_n == ST_DONE);
            if (w_accept && (w_op_n == OP_RSVD)) begin
                r_rsp_data  <= '0;
                r_rsp_flags <= '0;
                r_rsp_err   <= 1'b1;
            end else if (r_state == ST_EXEC) begin
                r_rsp_data                <= hold_REG_IN;
                r_rsp_flags[FLAG_N]       <= negative_FLAG_IN;
                r_rsp_flags[FLAG_V]       <= overflow_FLAG_IN;
                r_rsp_flags[FLAG_Z]       <= zero_FLAG_IN;
                r_rsp_flags[FLAG_C]       <= carryOut_FLAG_IN;
                r_rsp_err                 <= 1'b0;
            end
        end
    end

    assign req_ready          = r_req_ready;
    assign a_systemBus_EN     = r_ctrl.a_sys;
    assign a_zero_EN          = r_ctrl.a_zero;
    assign b_dataBus_EN       = r_ctrl.b_data;
    assign b_dataBusInvert_EN = r_ctrl.b_inv;
    assign b_addressLow_EN    = r_ctrl.b_addr;
    assign alu_sum_EN         = r_ctrl.alu_sum;
    assign alu_and_EN         = r_ctrl.alu_and;
    assign alu_or_EN          = r_ctrl.alu_or;
    assign alu_eor_EN         = r_ctrl.alu_eor;
    assign alu_shiftRight_EN  = r_ctrl.alu_shr;
    assign carry_FLAG_IN      = r_ctrl.carry_in;
    assign rsp_valid          = r_rsp_valid;
    assign rsp_data           = r_rsp_data;
    assign rsp_flags          = r_rsp_flags;
    assign rsp_err            = r_rsp_err;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: a behavioural A/B/ALU datapath reacts to the DUT's
// controls, results are compared with a table and an arithmetic reference.
`timescale 1ns/1ps
module tb_alu_sequencer;

    logic       phi2 = 1'b0;
    logic       reset = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [2:0] req_op = 3'd0;
    logic       req_b_src = 1'b0;
    logic       req_carry = 1'b0;
    logic       a_systemBus_EN, a_zero_EN;
    logic       b_dataBus_EN, b_dataBusInvert_EN, b_addressLow_EN;
    logic       alu_sum_EN, alu_and_EN, alu_or_EN, alu_eor_EN, alu_shiftRight_EN;
    logic       carry_FLAG_IN;
    logic [7:0] hold_REG_IN = 8'h00;
    logic       overflow_FLAG_IN = 1'b0, carryOut_FLAG_IN = 1'b0;
    logic       negative_FLAG_IN = 1'b0, zero_FLAG_IN = 1'b0;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [7:0] rsp_data;
    logic [3:0] rsp_flags;
    logic       rsp_err;

    alu_sequencer dut (
        .phi2(phi2), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_b_src(req_b_src), .req_carry(req_carry),
        .a_systemBus_EN(a_systemBus_EN), .a_zero_EN(a_zero_EN),
        .b_dataBus_EN(b_dataBus_EN), .b_dataBusInvert_EN(b_dataBusInvert_EN),
        .b_addressLow_EN(b_addressLow_EN),
        .alu_sum_EN(alu_sum_EN), .alu_and_EN(alu_and_EN), .alu_or_EN(alu_or_EN),
        .alu_eor_EN(alu_eor_EN), .alu_shiftRight_EN(alu_shiftRight_EN),
        .carry_FLAG_IN(carry_FLAG_IN), .hold_REG_IN(hold_REG_IN),
        .overflow_FLAG_IN(overflow_FLAG_IN), .carryOut_FLAG_IN(carryOut_FLAG_IN),
        .negative_FLAG_IN(negative_FLAG_IN), .zero_FLAG_IN(zero_FLAG_IN),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_flags(rsp_flags), .rsp_err(rsp_err)
    );

    always #5 phi2 = ~phi2;

    localparam int A_SYS = 10, A_ZERO = 9, B_DATA = 8, B_INV = 7, B_ADDR = 6;
    localparam int S_SUM = 5, S_AND = 4, S_OR = 3, S_EOR = 2, S_SHR = 1, C_IN = 0;

    logic [10:0] ctrl;
    assign ctrl = {a_systemBus_EN, a_zero_EN, b_dataBus_EN, b_dataBusInvert_EN,
                   b_addressLow_EN, alu_sum_EN, alu_and_EN, alu_or_EN, alu_eor_EN,
                   alu_shiftRight_EN, carry_FLAG_IN};

    int total = 0;
    int bad   = 0;
    logic [7:0] sys_bus = 8'h00, data_bus = 8'h00, addrl_bus = 8'h00;
    logic [7:0] dp_a = 8'h00, dp_b = 8'h00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [10:0] exp_load(input logic [2:0] op, input logic bs);
        logic [10:0] v;
        v = '0;
        case (op)
            3'd0, 3'd2, 3'd3, 3'd4: begin v[A_SYS] = 1'b1; v[bs ? B_ADDR : B_DATA] = 1'b1; end
            3'd1: begin v[A_SYS] = 1'b1; v[B_INV] = 1'b1; end
            3'd5: v[A_SYS] = 1'b1;
            3'd6: begin v[A_ZERO] = 1'b1; v[bs ? B_ADDR : B_DATA] = 1'b1; end
            default: ;
        endcase
        return v;
    endfunction

    function automatic logic [10:0] exp_exec(input logic [2:0] op, input logic c);
        logic [10:0] v;
        v = '0;
        case (op)
            3'd0, 3'd1: begin v[S_SUM] = 1'b1; v[C_IN] = c; end
            3'd2: v[S_AND] = 1'b1;
            3'd3: v[S_OR]  = 1'b1;
            3'd4: v[S_EOR] = 1'b1;
            3'd5: v[S_SHR] = 1'b1;
            3'd6: v[S_SUM] = 1'b1;
            default: ;
        endcase
        return v;
    endfunction

    // Reference result {N,V,Z,C,data} from operand values and op semantics.
    function automatic logic [11:0] ref_alu(input logic [2:0] op, input logic bs, input logic c,
                                            input logic [7:0] a, input logic [7:0] d,
                                            input logic [7:0] al);
        int ua, ub, sa, sb, u, s;
        logic [7:0] r;
        logic v, cf;
        ua = int'(a);
        ub = (bs && op != 3'd1 && op != 3'd5) ? int'(al) : int'(d);
        sa = (ua > 127) ? ua - 256 : ua;
        sb = (ub > 127) ? ub - 256 : ub;
        v = 1'b0; cf = 1'b0; u = 0;
        case (op)
            3'd0: begin u = ua + ub + int'(c); s = sa + sb + int'(c);
                        cf = (u > 255); v = (s > 127) || (s < -128); end
            3'd1: begin u = ua - ub - (1 - int'(c)); s = sa - sb - (1 - int'(c));
                        cf = (u >= 0); v = (s > 127) || (s < -128); end
            3'd2: u = ua & ub;
            3'd3: u = ua | ub;
            3'd4: u = ua ^ ub;
            3'd5: begin u = ua / 2; cf = a[0]; end
            3'd6: u = ub;
            default: return 12'h000;
        endcase
        r = u[7:0];
        return {r[7], v, (r == 8'h00), cf, r};
    endfunction

    // Behavioural datapath: registers loaded and ALU evaluated from the DUT's controls.
    always @(negedge phi2) begin
        logic [8:0] sum;
        logic [7:0] res;
        logic v, cf;
        if (a_systemBus_EN || a_zero_EN) begin
            dp_a = a_systemBus_EN ? sys_bus : 8'h00;
            dp_b = b_dataBus_EN ? data_bus : b_dataBusInvert_EN ? ~data_bus :
                   b_addressLow_EN ? addrl_bus : 8'h00;
        end
        if (alu_sum_EN || alu_and_EN || alu_or_EN || alu_eor_EN || alu_shiftRight_EN) begin
            v = 1'b0; cf = 1'b0; res = 8'h00;
            if (alu_sum_EN) begin
                sum = {1'b0, dp_a} + {1'b0, dp_b} + {8'h00, carry_FLAG_IN};
                res = sum[7:0]; cf = sum[8];
                v = (dp_a[7] == dp_b[7]) && (res[7] != dp_a[7]);
            end else if (alu_and_EN) res = dp_a & dp_b;
            else if (alu_or_EN)  res = dp_a | dp_b;
            else if (alu_eor_EN) res = dp_a ^ dp_b;
            else begin res = {1'b0, dp_a[7:1]}; cf = dp_a[0]; end
            hold_REG_IN = res; negative_FLAG_IN = res[7]; overflow_FLAG_IN = v;
            zero_FLAG_IN = (res == 8'h00); carryOut_FLAG_IN = cf;
        end else begin
            hold_REG_IN = 8'($urandom);
            {negative_FLAG_IN, overflow_FLAG_IN, zero_FLAG_IN, carryOut_FLAG_IN} = 4'($urandom);
        end
    end

    task automatic do_op(input string tag, input logic [2:0] op, input logic bs, input logic c,
                         input logic [7:0] a, input logic [7:0] d, input logic [7:0] al,
                         input logic [11:0] exp_fd, input logic exp_err,
                         input int wait_n, input bit poke);
        int guard;
        guard = 0;
        while (req_ready !== 1'b1 && guard < 10) begin @(negedge phi2); guard++; end
        chk({tag, ".ready"}, req_ready, 1);
        sys_bus = a; data_bus = d; addrl_bus = al;
        req_op = op; req_b_src = bs; req_carry = c; req_valid = 1'b1;
        @(negedge phi2);
        req_valid = 1'b0;
        if (op != 3'd7) begin
            chk({tag, ".load_ctrl"}, ctrl, exp_load(op, bs));
            chk({tag, ".busy_ready"}, req_ready, 0);
            chk({tag, ".early_valid"}, rsp_valid, 0);
            @(negedge phi2);
            chk({tag, ".exec_ctrl"}, ctrl, exp_exec(op, c));
            chk({tag, ".exec_valid"}, rsp_valid, 0);
            @(negedge phi2);
        end
        chk({tag, ".valid"}, rsp_valid, 1);
        chk({tag, ".done_ctrl"}, ctrl, 0);
        chk({tag, ".result"}, {rsp_flags, rsp_data}, exp_fd);
        chk({tag, ".err"}, rsp_err, exp_err);
        for (int i = 0; i < wait_n; i++) begin
            if (poke) begin req_valid = 1'b1; req_op = 3'($urandom_range(0, 7)); end
            @(negedge phi2);
            chk({tag, ".hold"}, {rsp_valid, rsp_err, rsp_flags, rsp_data}, {1'b1, exp_err, exp_fd});
            chk({tag, ".hold_ready"}, req_ready, 0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge phi2);
        rsp_ready = 1'b0;
        chk({tag, ".after_valid"}, rsp_valid, 0);
        chk({tag, ".after_ready"}, req_ready, 1);
    endtask

    typedef struct {
        logic [2:0]  op;
        logic        bs;
        logic        c;
        logic [7:0]  a;
        logic [7:0]  d;
        logic [7:0]  al;
        logic [11:0] fd;
        logic        err;
    } vec_t;

    vec_t tbl[14];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{3'd0, 1'b0, 1'b0, 8'h50, 8'hD0, 8'h11, 12'h120, 1'b0};
        tbl[1]  = '{3'd1, 1'b0, 1'b1, 8'h05, 8'h03, 8'hEE, 12'h102, 1'b0};
        tbl[2]  = '{3'd6, 1'b1, 1'b0, 8'h77, 8'h33, 8'h0A, 12'h00A, 1'b0};
        tbl[3]  = '{3'd7, 1'b0, 1'b1, 8'h12, 8'h34, 8'h56, 12'h000, 1'b1};
        tbl[4]  = '{3'd2, 1'b0, 1'b0, 8'hF0, 8'h3C, 8'h00, 12'h030, 1'b0};
        tbl[5]  = '{3'd3, 1'b1, 1'b0, 8'h0F, 8'h55, 8'h80, 12'h88F, 1'b0};
        tbl[6]  = '{3'd4, 1'b0, 1'b0, 8'hAA, 8'hAA, 8'h01, 12'h200, 1'b0};
        tbl[7]  = '{3'd5, 1'b1, 1'b1, 8'h81, 8'hFF, 8'hFF, 12'h140, 1'b0};
        tbl[8]  = '{3'd0, 1'b0, 1'b0, 8'h7F, 8'h01, 8'h00, 12'hC80, 1'b0};
        tbl[9]  = '{3'd1, 1'b1, 1'b1, 8'h00, 8'h01, 8'h99, 12'h8FF, 1'b0};
        tbl[10] = '{3'd0, 1'b1, 1'b1, 8'hFF, 8'h22, 8'h01, 12'h101, 1'b0};
        tbl[11] = '{3'd6, 1'b0, 1'b0, 8'h12, 8'h00, 8'h34, 12'h200, 1'b0};
        tbl[12] = '{3'd1, 1'b0, 1'b0, 8'h05, 8'h03, 8'h44, 12'h101, 1'b0};
        tbl[13] = '{3'd7, 1'b1, 1'b0, 8'hFF, 8'hFF, 8'hFF, 12'h000, 1'b1};

        // Reset state, then req_ready rises the cycle after release.
        repeat (2) @(negedge phi2);
        chk("rst.ctrl", ctrl, 0);
        chk("rst.valid", rsp_valid, 0);
        chk("rst.data", rsp_data, 0);
        chk("rst.flags", rsp_flags, 0);
        chk("rst.err", rsp_err, 0);
        chk("rst.ready", req_ready, 0);
        reset = 1'b0;
        @(negedge phi2);
        chk("rst.ready_after", req_ready, 1);

        for (int i = 0; i < 14; i++)
            do_op($sformatf("tbl%0d", i), tbl[i].op, tbl[i].bs, tbl[i].c, tbl[i].a,
                  tbl[i].d, tbl[i].al, tbl[i].fd, tbl[i].err, (i == 0) ? 5 : i % 3, i == 0);

        // Reset during EXEC aborts with no response.
        sys_bus = 8'h11; data_bus = 8'h22;
        req_op = 3'd0; req_b_src = 1'b0; req_carry = 1'b0; req_valid = 1'b1;
        @(negedge phi2);
        req_valid = 1'b0;
        @(negedge phi2);
        reset = 1'b1;
        @(negedge phi2);
        chk("rexec.ctrl", ctrl, 0);
        chk("rexec.valid", rsp_valid, 0);
        chk("rexec.ready", req_ready, 0);
        reset = 1'b0;
        @(negedge phi2);
        chk("rexec.ready_after", req_ready, 1);
        @(negedge phi2);
        chk("rexec.no_rsp", rsp_valid, 0);

        // Reset during DONE clears the pending response.
        sys_bus = 8'h80; data_bus = 8'h80;
        req_op = 3'd0; req_valid = 1'b1;
        @(negedge phi2);
        req_valid = 1'b0;
        repeat (2) @(negedge phi2);
        chk("rdone.valid_before", rsp_valid, 1);
        reset = 1'b1;
        @(negedge phi2);
        chk("rdone.valid", rsp_valid, 0);
        chk("rdone.result", {rsp_err, rsp_flags, rsp_data}, 0);
        reset = 1'b0;
        @(negedge phi2);

        for (int n = 0; n < 40; n++) begin
            logic [2:0] op;
            logic bs, c;
            logic [7:0] a, d, al;
            op = 3'($urandom_range(0, 7));
            bs = 1'($urandom); c = 1'($urandom);
            a = 8'($urandom); d = 8'($urandom); al = 8'($urandom);
            do_op($sformatf("rnd%0d", n), op, bs, c, a, d, al, ref_alu(op, bs, c, a, d, al),
                  op == 3'd7, int'($urandom_range(0, 2)), 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
